mult_div_unit: RTL and testbench

- Multi-cycle multiply/divide unit with the architectural HI/LO registers.
- Sits directly downstream of the ALU control decoder: consumes its 3-bit mult/div opcode plus the rs/rt operands.
- Executes MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO.
- Raises busy while an iterative operation is in flight; the core stalls on busy.

---
 rtl/mips_muldiv_pkg.sv | 28 ++
 rtl/muldiv_engine.sv | 75 +++++++
 rtl/mult_div_unit.sv | 131 +++++++++++++
 tb/tb_mult_div_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared types for the multiply/divide unit: decoder opcode encoding and FSM states.
`default_nettype none

package mips_muldiv_pkg;

   localparam int MD_WIDTH = 32;

   // Bit-for-bit identical to the ALU control decoder's mult/div field
   typedef enum logic [2:0] {
      MD_DIVU  = 3'b000,
      MD_MULTU = 3'b001,
      MD_DIV   = 3'b010,
      MD_MULT  = 3'b011,
      MD_MTHI  = 3'b100,
      MD_MTLO  = 3'b101,
      MD_MFHI  = 3'b110,
      MD_MFLO  = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10
   } md_state_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_engine.sv
// Unsigned radix-2 shift-add multiplier / restoring divider sharing one 2*WIDTH accumulator.
`default_nettype none

module muldiv_engine
   import mips_muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH,
   parameter int ITER  = WIDTH
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               load_i,
   input  logic               step_i,
   input  logic               is_div_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               last_o,
   output logic [2*WIDTH-1:0] acc_o
);

   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   m_q, m_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               div_q, div_d;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;

   // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}
   always_comb begin
      acc_d     = acc_q;
      m_d       = m_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
      div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, m_q};
      if (load_i) begin
         acc_d = {{WIDTH{1'b0}}, (is_div_i ? a_i : b_i)};
         m_d   = is_div_i ? b_i : a_i;
         cnt_d = '0;
         div_d = is_div_i;
      end else if (step_i) begin
         cnt_d = cnt_q + 1'b1;
         if (div_q) begin
            if (!div_trial[WIDTH])
               acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
               acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
         end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q <= '0;
         m_q   <= '0;
         cnt_q <= '0;
         div_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         m_q   <= m_d;
         cnt_q <= cnt_d;
         div_q <= div_d;
      end
   end

   assign last_o = (cnt_q == CW'(ITER - 1));
   assign acc_o  = acc_q;

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/DIV unit owning HI/LO, sign correction and the MTHI/MTLO/MFHI/MFLO paths.
`default_nettype none

module mult_div_unit
   import mips_muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH,
   parameter int ITER  = WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] mf_data,
   output logic             mf_valid
);

   md_state_e          state_q, state_d;
   md_op_e             op_e;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, mf_data_q, mf_data_d;
   logic               mf_valid_q, mf_valid_d;
   logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d;
   logic               div_q, div_d, bzero_q, bzero_d;
   logic               w_signed, w_neg_a, w_neg_b, w_load, eng_last;
   logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_quot, w_rem;
   logic [2*WIDTH-1:0] eng_acc, w_prod;

   assign op_e     = md_op_e'(op);
   assign w_signed = op[1];
   assign w_neg_a  = w_signed & a[WIDTH-1];
   assign w_neg_b  = w_signed & b[WIDTH-1];
   assign w_a_mag  = w_neg_a ? (~a + 1'b1) : a;
   assign w_b_mag  = w_neg_b ? (~b + 1'b1) : b;
   assign w_load   = (state_q == IDLE) && start && !op[2];

   muldiv_engine #(.WIDTH(WIDTH), .ITER(ITER)) u_engine (
      .clk      (clk),
      .reset_n  (reset_n),
      .load_i   (w_load),
      .step_i   (state_q == RUN),
      .is_div_i (!op[0]),
      .a_i      (w_a_mag),
      .b_i      (w_b_mag),
      .last_o   (eng_last),
      .acc_o    (eng_acc)
   );

   // A zero divisor leaves the all-ones quotient uncorrected; remainder follows the dividend
   assign w_prod = (neg_a_q ^ neg_b_q) ? (~eng_acc + 1'b1) : eng_acc;
   assign w_quot = ((neg_a_q ^ neg_b_q) && !bzero_q) ? (~eng_acc[WIDTH-1:0] + 1'b1)
                                                     : eng_acc[WIDTH-1:0];
   assign w_rem  = neg_a_q ? (~eng_acc[2*WIDTH-1:WIDTH] + 1'b1) : eng_acc[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d    = state_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      mf_data_d  = mf_data_q;
      mf_valid_d = 1'b0;
      neg_a_d    = neg_a_q;
      neg_b_d    = neg_b_q;
      div_d      = div_q;
      bzero_d    = bzero_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               case (op_e)
                  MD_MTHI: hi_d = a;
                  MD_MTLO: lo_d = a;
                  MD_MFHI: begin mf_data_d = hi_q; mf_valid_d = 1'b1; end
                  MD_MFLO: begin mf_data_d = lo_q; mf_valid_d = 1'b1; end
                  default: begin
                     state_d = RUN;
                     neg_a_d = w_neg_a;
                     neg_b_d = w_neg_b;
                     div_d   = !op[0];
                     bzero_d = (b == '0);
                  end
               endcase
            end
         end
         RUN: if (eng_last) state_d = FIX;
         FIX: begin
            state_d = IDLE;
            if (div_q) {hi_d, lo_d} = {w_rem, w_quot};
            else       {hi_d, lo_d} = w_prod;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         hi_q       <= '0;
         lo_q       <= '0;
         mf_data_q  <= '0;
         mf_valid_q <= 1'b0;
         neg_a_q    <= 1'b0;
         neg_b_q    <= 1'b0;
         div_q      <= 1'b0;
         bzero_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         mf_data_q  <= mf_data_d;
         mf_valid_q <= mf_valid_d;
         neg_a_q    <= neg_a_d;
         neg_b_q    <= neg_b_d;
         div_q      <= div_d;
         bzero_q    <= bzero_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == FIX);
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign mf_data  = mf_data_q;
   assign mf_valid = mf_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed HI/LO results.
`default_nettype none

module tb_mult_div_unit;

   localparam logic [2:0] OP_DIVU = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010, OP_MULT = 3'b011;
   localparam logic [2:0] OP_MTHI = 3'b100, OP_MTLO = 3'b101, OP_MFHI = 3'b110, OP_MFLO = 3'b111;

   logic        clk = 1'b0;
   logic        reset_n, start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy, done, mf_valid;
   logic [31:0] hi, lo, mf_data;

   int errors = 0;
   int checks = 0;

   mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo),
      .mf_data  (mf_data),
      .mf_valid (mf_valid)
   );

   always #5 clk = ~clk;

   // One-cycle start pulse; operands are scrambled after acceptance to prove they were latched
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      #1;
      start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
   endtask

   task automatic wait_idle(output int cyc, output int done_at, output int done_cnt);
      cyc = 0; done_at = -1; done_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) break;
         cyc++;
         if (done) begin done_cnt++; done_at = cyc; end
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
      #1;
      checks++;
      if ({busy, done, mf_valid} !== 3'b000 || hi !== 32'h0 || lo !== 32'h0 || mf_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b mf_valid=%b hi=%h lo=%h mf_data=%h, need all 0",
                  busy, done, mf_valid, hi, lo, mf_data);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_multu_latency;
      int cyc, done_at, done_cnt;
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_idle(cyc, done_at, done_cnt);
      checks++;
      if (cyc !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d need 33", cyc); end
      checks++;
      if (done_at !== 33 || done_cnt !== 1) begin
         errors++; $display("FAIL multu_done: at %0d count %0d, need at 33 count 1", done_at, done_cnt);
      end
      checks++;
      if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
         errors++; $display("FAIL multu_result: hi=%h lo=%h need FFFFFFFE 00000001", hi, lo);
      end
   endtask

   task automatic test_signed_ops;
      int cyc, done_at, done_cnt;
      issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
      wait_idle(cyc, done_at, done_cnt);
      checks++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
         errors++; $display("FAIL mult_neg3x5: hi=%h lo=%h need FFFFFFFF FFFFFFF1", hi, lo);
      end
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_idle(cyc, done_at, done_cnt);
      checks++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD || cyc !== 33) begin
         errors++; $display("FAIL div_neg7by2: hi=%h lo=%h cyc=%0d need FFFFFFFF FFFFFFFD 33", hi, lo, cyc);
      end
   endtask

   task automatic test_div_corner;
      int cyc, done_at, done_cnt;
      issue(OP_DIVU, 32'd7, 32'd0);
      wait_idle(cyc, done_at, done_cnt);
      checks++;
      if (hi !== 32'd7 || lo !== 32'hFFFF_FFFF || cyc !== 33) begin
         errors++; $display("FAIL divu_by_zero: hi=%h lo=%h cyc=%0d need 00000007 FFFFFFFF 33", hi, lo, cyc);
      end
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(cyc, done_at, done_cnt);
      checks++;
      if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
         errors++; $display("FAIL div_overflow: hi=%h lo=%h need 00000000 80000000", hi, lo);
      end
   endtask

   task automatic test_mthi_mfhi;
      @(negedge clk);
      start = 1'b1; op = OP_MTHI; a = 32'h0000_1234;
      @(posedge clk);
      #1;
      op = OP_MFHI; a = 32'h0;
      @(negedge clk);
      checks++;
      if (hi !== 32'h1234 || busy !== 1'b0 || mf_valid !== 1'b0) begin
         errors++; $display("FAIL mthi_write: hi=%h busy=%b mf_valid=%b need 00001234 0 0", hi, busy, mf_valid);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (mf_valid !== 1'b1 || mf_data !== 32'h1234) begin
         errors++; $display("FAIL mfhi_read: mf_valid=%b mf_data=%h need 1 00001234", mf_valid, mf_data);
      end
      @(negedge clk);
      checks++;
      if (mf_valid !== 1'b0) begin errors++; $display("FAIL mfhi_pulse: mf_valid=%b need 0", mf_valid); end
   endtask

   task automatic test_back_to_back;
      logic [2:0]  ign_op [3] = '{OP_MULT, OP_MTLO, OP_MFLO};
      logic [31:0] ign_a  [3] = '{32'd2, 32'h0000_00AA, 32'd0};
      int mfv = 0, both = 0, cyc = 0;
      issue(OP_MULT, 32'd6, 32'd7);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (mf_valid) mfv++;
         if (mf_valid && done) both++;
         if (!busy) break;
         cyc++;
         if (i >= 2 && i <= 4) begin
            start = 1'b1; op = ign_op[i-2]; a = ign_a[i-2]; b = 32'd2;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      @(negedge clk);
      if (mf_valid) mfv++;
      checks++;
      if (lo !== 32'd42 || hi !== 32'h0 || cyc !== 33) begin
         errors++; $display("FAIL ignore_busy_result: hi=%h lo=%h cyc=%0d need 0 42 33", hi, lo, cyc);
      end
      checks++;
      if (mfv !== 0 || both !== 0) begin
         errors++; $display("FAIL ignore_busy_mf: mf_valid pulses=%0d overlap=%0d need 0 0", mfv, both);
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_requeue: busy=%b need 0", busy); end
   endtask

   task automatic test_async_reset;
      int cyc, done_at, done_cnt;
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'd3);
      repeat (10) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin
         errors++; $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h need 0 0 0 0", busy, done, hi, lo);
      end
      @(negedge clk);
      reset_n = 1'b1;
      issue(OP_MULTU, 32'd3, 32'd4);
      wait_idle(cyc, done_at, done_cnt);
      checks++;
      if (lo !== 32'd12 || hi !== 32'h0 || cyc !== 33) begin
         errors++; $display("FAIL after_reset_multu: hi=%h lo=%h cyc=%0d need 0 12 33", hi, lo, cyc);
      end
   endtask

   initial begin
      test_reset();
      test_multu_latency();
      test_signed_ops();
      test_div_corner();
      test_mthi_mfhi();
      test_back_to_back();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
